// File: rtl/sparse_enc_if.sv
// Stream bundle for the sparse encoder: dense input stream and sparse output stream.
// master drives in_*/out_ready (producer+consumer side), slave is the encoder.
interface sparse_enc_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/sparse_enc.sv
// Zero-run sparse encoder: dense elements in, (value, zeros-skipped, last) entries out.
// Ports: clk, rst (async active-high), bus (sparse_enc_if.slave),
// nnz_cnt (only when SPARSE_ENC_STAT_EN is defined: entries emitted in current/last frame).
module sparse_enc #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    sparse_enc_if.slave      bus
`ifdef SPARSE_ENC_STAT_EN
    ,
    output logic [CNT_W-1:0] nnz_cnt
`endif
);
    localparam logic [IDX_W-1:0] RUN_MAX = '1;

    logic              accept;
    logic              xfer;
    logic              is_zero;
    logic              emit;
    logic [IDX_W-1:0]  run;
    logic [IDX_W-1:0]  run_nxt;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  idx_q;
    logic              last_q;

    // The single output register may be refilled on the same edge it drains.
    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;

    // An entry is produced for a nonzero, for any frame end, and for a
    // zero that would overflow the run counter (filler entry (0, RUN_MAX)).
    always_comb begin
        accept  = bus.in_valid && bus.in_ready;
        xfer    = valid_q && bus.out_ready;
        is_zero = (bus.in_data == '0);
        emit    = accept && (!is_zero || bus.in_last || run == RUN_MAX);
        run_nxt = run;
        if (accept) begin
            if (emit) begin
                run_nxt = '0;
            end else begin
                run_nxt = run + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= '0;
        end else begin
            run <= run_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else if (emit) begin
            // A zero element carries value 0, so in_data is correct for fillers too.
            valid_q <= 1'b1;
            data_q  <= bus.in_data;
            idx_q   <= run;
            last_q  <= bus.in_last;
        end else if (xfer) begin
            valid_q <= 1'b0;
        end
    end

`ifdef SPARSE_ENC_STAT_EN
    // frame_done marks that the previous transfer closed a frame, so the
    // next transfer restarts the count at one.
    logic frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nnz_cnt    <= '0;
            frame_done <= 1'b0;
        end else if (xfer) begin
            frame_done <= last_q;
            if (frame_done) begin
                nnz_cnt <= CNT_W'(1);
            end else if (nnz_cnt != '1) begin
                nnz_cnt <= nnz_cnt + CNT_W'(1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_sparse_enc.sv
// Self-checking bench for sparse_enc: behavioural model + decode check + literal cases.
// Compile with -DSPARSE_ENC_STAT_EN to also check nnz_cnt.
module tb_sparse_enc;
    typedef struct packed {
        logic [7:0] d;
        logic [3:0] i;
        logic       l;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nmis = 0;
    int   rdy_mode = 0;

    always #5 clk = ~clk;

    sparse_enc_if #(.DATA_W(8), .IDX_W(4)) bus ();

`ifdef SPARSE_ENC_STAT_EN
    logic [15:0] nnz_cnt;
    sparse_enc #(.DATA_W(8), .IDX_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .nnz_cnt(nnz_cnt)
    );
`else
    sparse_enc #(.DATA_W(8), .IDX_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t       q[$];
    ent_t       got[$];
    logic [8:0] dq[$];
    int         zeros = 0;
    int         st_cnt = 0;
    bit         st_prev_last = 0;

    function automatic logic [31:0] dpop();
        if (dq.size() == 0) return 32'hDEAD;
        return {23'b0, dq.pop_front()};
    endfunction

    always @(negedge clk) begin
        bit   exp_ov;
        bit   exp_rdy;
        ent_t e;
        if (rst) begin
            q.delete();
            dq.delete();
            zeros = 0;
            st_cnt = 0;
            st_prev_last = 0;
            chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
            chk("rst_out_data", {24'b0, bus.out_data}, 0);
            chk("rst_out_idx", {28'b0, bus.out_idx}, 0);
            chk("rst_out_last", {31'b0, bus.out_last}, 0);
`ifdef SPARSE_ENC_STAT_EN
            chk("rst_nnz_cnt", {16'b0, nnz_cnt}, 0);
`endif
        end else begin
            exp_ov  = (q.size() != 0);
            exp_rdy = !exp_ov || bus.out_ready;
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_ov});
            chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
`ifdef SPARSE_ENC_STAT_EN
            chk("nnz_cnt", {16'b0, nnz_cnt}, st_cnt);
`endif
            if (exp_ov) begin
                e = q[0];
                chk("out_entry", {19'b0, bus.out_data, bus.out_idx, bus.out_last}, {19'b0, e});
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    got.push_back(e);
                    for (int k = 0; k < int'(e.i); k++) chk("decode_zero", dpop(), 0);
                    chk("decode_val", dpop(), {23'b0, e.l, e.d});
                    st_cnt = st_prev_last ? 1 : st_cnt + 1;
                    st_prev_last = e.l;
                end
            end
            if (bus.in_valid && exp_rdy) begin
                dq.push_back({bus.in_last, bus.in_data});
                if (bus.in_data != 0 || bus.in_last || zeros == 15) begin
                    q.push_back('{d: bus.in_data, i: 4'(zeros), l: bus.in_last});
                    zeros = 0;
                end else begin
                    zeros++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    task automatic send(input logic [7:0] d, input logic l);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 1, 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (q.size() == 0) return;
            @(posedge clk);
            #2;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    function automatic ent_t mk(input logic [7:0] d, input logic [3:0] i, input logic l);
        return '{d: d, i: i, l: l};
    endfunction

    ent_t lit[$];

    task automatic check_lit(input string nm);
        chk({nm, "_count"}, got.size(), lit.size());
        for (int k = 0; k < lit.size() && k < got.size(); k++)
            chk({nm, "_entry"}, {19'b0, got[k]}, {19'b0, lit[k]});
        got.delete();
        lit.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("in_ready_after_rst", {31'b0, bus.in_ready}, 1);
        got.delete();

        // frame [0,0,5,0,-3(last)]
        send(0, 0); send(0, 0); send(5, 0); send(0, 0); send(8'hFD, 1);
        drain();
        lit.push_back(mk(5, 2, 0)); lit.push_back(mk(8'hFD, 1, 1));
        check_lit("frame_a");

        // 17 zeros then 7(last)
        for (int k = 0; k < 17; k++) send(0, 0);
        send(7, 1);
        drain();
        lit.push_back(mk(0, 15, 0)); lit.push_back(mk(7, 1, 1));
        check_lit("frame_run");

        // [4,0,0(last)] then [9(last)] back-to-back
        send(4, 0); send(0, 0); send(0, 1); send(9, 1);
        drain();
        lit.push_back(mk(4, 0, 0)); lit.push_back(mk(0, 1, 1));
        lit.push_back(mk(9, 0, 1));
        check_lit("frame_b2b");

        // stall: out_ready low 3 cycles with entry pending
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(3, 1);
        fork
            send(8, 1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'b0, bus.in_ready}, 0);
                    chk("stall_hold", {19'b0, bus.out_data, bus.out_idx, bus.out_last},
                        {19'b0, mk(3, 0, 1)});
                end
                rdy_mode = 0;
            end
        join
        drain();
        lit.push_back(mk(3, 0, 1)); lit.push_back(mk(8, 0, 1));
        check_lit("stall");

        // reset mid-frame
        send(0, 0); send(0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        send(6, 1);
        drain();
        lit.push_back(mk(6, 0, 1));
        check_lit("after_rst");

`ifdef SPARSE_ENC_STAT_EN
        send(1, 0); send(0, 0); send(2, 0); send(3, 1);
        drain();
        @(negedge clk);
        chk("stat_frame", {16'b0, nnz_cnt}, 3);
        @(posedge clk);
        #1;
        send(9, 1);
        drain();
        @(negedge clk);
        chk("stat_next", {16'b0, nnz_cnt}, 1);
        @(posedge clk);
        #1;
        got.delete();
`endif

        // randomized frames with random backpressure and gaps
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            bit all_zero;
            len = $urandom_range(1, 40);
            all_zero = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < len; k++) begin
                logic [7:0] v;
                if (all_zero || $urandom_range(0, 9) < 7) v = 8'd0;
                else v = 8'($urandom_range(1, 255));
                if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2));
                send(v, k == len - 1);
            end
        end
        rdy_mode = 0;
        drain();
        @(posedge clk);
        #1;
        chk("dense_consumed", dq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
